ram_burst_ctrl: RTL and testbench

//  Request sequencer directly upstream of the 1024x8 async-write RAM (ram_3).
//  - Accepts single or burst read/write requests over valid/ready.
//  - Drives the RAM's addr/data_in/wr/cs pins with setup/strobe/hold timing.
//  - Returns read data on a backpressured rdata stream.
//  - Converts the RAM's level-sensitive, combinational-read port into a clean synchronous interface.

---
 rtl/ram_ctrl_pkg.sv | 21 ++
 rtl/ram_addr_gen.sv | 50 +++++
 rtl/ram_burst_ctrl.sv | 135 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst controller and its RAM instantiation.
package ram_ctrl_pkg;

  // Default geometry of the 1024x8 asynchronous-write RAM.
  localparam int ADDR_SIZE_DEF = 10;
  localparam int WORD_SIZE_DEF = 8;
  localparam int LEN_W_DEF     = 4;

  // Burst sequencer states: one write path and one read path, both returning to IDLE.
  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_ADDR,
    RD_CAPT,
    RD_WAIT
  } state_e;

endpackage

// File: rtl/ram_addr_gen.sv
// Burst address register with modulo wrap-around plus a beat down-counter.
module ram_addr_gen
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_addr,
  input  logic [LEN_W-1:0]     load_len,
  input  logic                 advance,
  output logic [ADDR_SIZE-1:0] addr,
  output logic                 last
);

  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;

  // Load a new burst, or step to the next beat; the adder wraps at 2**ADDR_SIZE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = load_addr;
      cnt_d  = load_len;
    end else if (advance) begin
      addr_d = addr_q + ADDR_SIZE'(1);
      cnt_d  = cnt_q - LEN_W'(1);
    end
  end

  // Address and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst request sequencer that drives an async-write, combinational-read RAM
// with setup/strobe/hold timing and returns read data on a backpressured stream.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 wdata_valid,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 wdata_ready,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rdata_last,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [WORD_SIZE-1:0] ram_data_out
);

  state_e state_q, state_d;

  logic                 wdata_ready_q, wdata_ready_d;
  logic                 ram_wr_q, ram_wr_d;
  logic                 ram_cs_q, ram_cs_d;
  logic                 rdata_valid_q, rdata_valid_d;
  logic                 rdata_last_q, rdata_last_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [WORD_SIZE-1:0] ram_data_in_q, ram_data_in_d;

  logic accept;
  logic wbeat;
  logic rbeat;
  logic advance;
  logic last;

  // Requests are taken only from IDLE and never while reset is held.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign wbeat     = wdata_valid && wdata_ready_q;
  assign rbeat     = rdata_valid_q && rdata_ready;

  // Step to the next beat after a write hold or a read handshake, unless it was the last one.
  assign advance = !last && (((state_q == WR_HOLD)) || ((state_q == RD_WAIT) && rbeat));

  ram_addr_gen #(
    .ADDR_SIZE (ADDR_SIZE),
    .LEN_W     (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (req_addr),
    .load_len  (req_len),
    .advance   (advance),
    .addr      (ram_addr),
    .last      (last)
  );

  // Next state plus registered-output values derived from the state being entered,
  // so every RAM pin changes only on a clock edge and stays aligned with the FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = req_wr ? WR_WAIT : RD_ADDR;
      WR_WAIT:   if (wbeat) state_d = WR_SETUP;
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD:   state_d = last ? IDLE : WR_WAIT;
      RD_ADDR:   state_d = RD_CAPT;
      RD_CAPT:   state_d = RD_WAIT;
      RD_WAIT:   if (rbeat) state_d = last ? IDLE : RD_ADDR;
      default:   state_d = IDLE;
    endcase

    wdata_ready_d = (state_d == WR_WAIT);
    ram_wr_d      = (state_d == WR_STROBE);
    ram_cs_d      = (state_d != IDLE);
    rdata_valid_d = (state_d == RD_WAIT);

    ram_data_in_d = ram_data_in_q;
    if (wbeat) ram_data_in_d = wdata;

    rdata_d      = rdata_q;
    rdata_last_d = (state_d == RD_WAIT) ? rdata_last_q : 1'b0;
    if (state_q == RD_CAPT) begin
      rdata_d      = ram_data_out;
      rdata_last_d = last;
    end
  end

  // State and output registers; reset aborts any burst on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wdata_ready_q <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_cs_q      <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      rdata_q       <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      wdata_ready_q <= wdata_ready_d;
      ram_wr_q      <= ram_wr_d;
      ram_cs_q      <= ram_cs_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      rdata_q       <= rdata_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign wdata_ready = wdata_ready_q;
  assign ram_wr      = ram_wr_q;
  assign ram_cs      = ram_cs_q;
  assign ram_data_in = ram_data_in_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_last  = rdata_last_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural RAM and reference memory.
module tb_ram_burst_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          ram_wr, ram_cs;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wdata_valid  (wdata_valid),
    .wdata        (wdata),
    .wdata_ready  (wdata_ready),
    .rdata_valid  (rdata_valid),
    .rdata_ready  (rdata_ready),
    .rdata        (rdata),
    .rdata_last   (rdata_last),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_wr       (ram_wr),
    .ram_cs       (ram_cs),
    .ram_data_out (ram_data_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 7 + 3);
  endfunction

  // Behavioural RAM: power-up pattern, level write while cs&wr, combinational read.
  logic [DW-1:0] ram_mem [DEPTH];
  bit            ram_init = 1'b0;
  assign ram_data_out = ram_mem[ram_addr];

  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ram_cs && ram_wr) begin
      ram_mem[ram_addr] <= ram_data_in;
    end
  end

  // Reference memory: the contents the RAM should hold after every completed beat.
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } rd_exp_t;
  wr_exp_t exp_wr_q [$];
  rd_exp_t exp_rd_q [$];

  // Consumer readiness: forced level or random backpressure.
  bit rr_force = 1'b1;
  bit rr_val   = 1'b1;
  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdata_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected strobes/read beats and checks pin timing around them.
  wr_exp_t       mw;
  rd_exp_t       mr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_din, p_rdata;
  logic          p_wr, p_valid, p_rdy, p_last, p_ok = 1'b0;

  always @(negedge clk) begin
    if (!rst && p_ok) begin
      check("cs_vs_busy", ram_cs, busy);
      check("req_ready_vs_busy", req_ready, !busy);
      if (ram_wr) begin
        check("wr_expected", ram_wr, exp_wr_q.size() != 0);
        if (exp_wr_q.size() != 0) begin
          mw = exp_wr_q.pop_front();
          check("wr_addr", ram_addr, mw.addr);
          check("wr_data", ram_data_in, mw.data);
        end
        check("wr_single_cycle", p_wr, 0);
        check("wr_setup_addr", ram_addr, p_addr);
        check("wr_setup_data", ram_data_in, p_din);
        check("wr_not_in_wait", wdata_ready, 0);
      end
      if (p_wr && !ram_wr) begin
        check("wr_hold_addr", ram_addr, p_addr);
        check("wr_hold_data", ram_data_in, p_din);
      end
      if (p_valid && !p_rdy) begin
        check("rd_hold_valid", rdata_valid, 1);
        check("rd_hold_data", rdata, p_rdata);
        check("rd_hold_last", rdata_last, p_last);
        check("rd_hold_addr", ram_addr, p_addr);
      end
      if (rdata_valid) check("rd_no_wr", ram_wr, 0);
      if (rdata_valid && rdata_ready) begin
        check("rd_expected", rdata_valid, exp_rd_q.size() != 0);
        if (exp_rd_q.size() != 0) begin
          mr = exp_rd_q.pop_front();
          check("rd_data", rdata, mr.data);
          check("rd_last", rdata_last, mr.last);
        end
      end
    end
    p_ok    <= !rst;
    p_addr  <= ram_addr;
    p_din   <= ram_data_in;
    p_wr    <= ram_wr;
    p_valid <= rdata_valid;
    p_rdy   <= rdata_ready;
    p_rdata <= rdata;
    p_last  <= rdata_last;
  end

  logic [DW-1:0] wbuf [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ram_wr"}, ram_wr, 0);
    check({tag, "_ram_cs"}, ram_cs, 0);
    check({tag, "_rdata_valid"}, rdata_valid, 0);
    check({tag, "_rdata_last"}, rdata_last, 0);
    check({tag, "_wdata_ready"}, wdata_ready, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_data_in"}, ram_data_in, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_req(input logic wr, input int addr, input int len);
    int n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    while (!req_ready && n < 200) begin step(); n++; end
    check("req_ready_wait", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic send_wbeat(input logic [DW-1:0] d, input int gap);
    int n = 0;
    wdata_valid = 1'b0;
    repeat (gap) begin wdata = DW'($urandom); step(); end
    wdata_valid = 1'b1;
    wdata       = d;
    while (!wdata_ready && n < 200) begin step(); n++; end
    check("wdata_ready_wait", wdata_ready, 1);
    step();
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin step(); n++; end
    check("wait_idle", busy, 0);
  endtask

  task automatic push_read(input int addr, input int len);
    int a;
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % DEPTH;
      exp_rd_q.push_back('{ref_mem[a], (i == len)});
    end
  endtask

  task automatic wr_burst(input int addr, input int len, input int gap);
    int a;
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % DEPTH;
      exp_wr_q.push_back('{AW'(a), wbuf[i]});
      ref_mem[a] = wbuf[i];
    end
    do_req(1'b1, addr, len);
    for (int i = 0; i <= len; i++) send_wbeat(wbuf[i], gap);
    wait_idle();
    check("wr_queue_drained", exp_wr_q.size(), 0);
  endtask

  task automatic rd_burst(input int addr, input int len);
    push_read(addr, len);
    do_req(1'b0, addr, len);
    wait_idle();
    check("rd_queue_drained", exp_rd_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a;
    logic [DW-1:0] sv_d;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    repeat (3) step();
    check_reset_vals("reset");
    check("reset_req_ready", req_ready, 0);
    rst = 1'b0;
    step();
    check("req_ready_after_rst", req_ready, 1);

    // T1: single write then read.
    wbuf[0] = 8'hA5;
    wr_burst(32'h005, 0, 0);
    rd_burst(32'h005, 0);

    // T2: burst across the top of the address space.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    wr_burst(32'h3FE, 3, 0);
    rd_burst(32'h3FE, 3);

    // T3: read backpressure for 5 cycles.
    rr_force = 1'b1; rr_val = 1'b0;
    push_read(32'h3FF, 1);
    do_req(1'b0, 32'h3FF, 1);
    n = 0;
    while (!rdata_valid && n < 50) begin step(); n++; end
    check("t3_valid", rdata_valid, 1);
    sv_d = rdata;
    check("t3_first_data", rdata, 8'h22);
    repeat (5) begin
      step();
      check("t3_hold_valid", rdata_valid, 1);
      check("t3_hold_data", rdata, sv_d);
      check("t3_hold_addr", ram_addr, 10'h3FF);
    end
    rr_val = 1'b1;
    wait_idle();
    check("t3_queue_drained", exp_rd_q.size(), 0);

    // T4: write stall with 4-cycle data gaps.
    wbuf[0] = 8'h5C; wbuf[1] = 8'hC3;
    wr_burst(32'h0A0, 1, 4);
    rd_burst(32'h0A0, 1);

    // T5: request held high through a 4-beat read.
    rr_force = 1'b0;
    push_read(32'h3FE, 3);
    push_read(32'h3FE, 3);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h3FE; req_len = 4'd3;
    n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    step();
    check("t5_first_accept", busy, 1);
    n = 0;
    while (busy && n < 2000) begin
      check("t5_ready_low", req_ready, 0);
      step();
      n++;
    end
    check("t5_ready_in_idle", req_ready, 1);
    step();
    check("t5_second_accept", busy, 1);
    req_valid = 1'b0;
    wait_idle();
    check("t5_queue_drained", exp_rd_q.size(), 0);

    // T6: reset in WR_SETUP of beat 2 of a 4-beat write.
    for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
    exp_wr_q.push_back('{10'h100, wbuf[0]});
    ref_mem[32'h100] = wbuf[0];
    do_req(1'b1, 32'h100, 3);
    send_wbeat(wbuf[0], 0);
    send_wbeat(wbuf[1], 0);
    check("t6_setup_data", ram_data_in, wbuf[1]);
    check("t6_setup_wr", ram_wr, 0);
    rst = 1'b1;
    step();
    check_reset_vals("t6");
    step();
    check("t6_no_strobe", ram_wr, 0);
    rst = 1'b0;
    step();
    check("t6_req_ready", req_ready, 1);
    check("t6_wr_queue", exp_wr_q.size(), 0);
    rd_burst(32'h100, 1);

    // Randomized mix of bursts under random backpressure.
    rr_force = 1'b0;
    for (int t = 0; t < 24; t++) begin
      a = ($urandom_range(0, 3) == 0) ? (1020 + $urandom_range(0, 3)) : $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= n; i++) wbuf[i] = DW'($urandom);
        wr_burst(a, n, $urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) rd_burst(a, n);
      end else begin
        rd_burst(a, n);
      end
    end

    check("final_wr_queue", exp_wr_q.size(), 0);
    check("final_rd_queue", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
